// File: rtl/mix_column_serial_if.sv
// Byte-serial MixColumns stream bus. The inv select exists only when MIXCOL_INVERSE_EN is defined.
interface mix_column_serial_if;
    logic       in_valid;
    logic [7:0] data_in;
    logic       bypass;
`ifdef MIXCOL_INVERSE_EN
    logic       inv;
`endif
    logic [7:0] data_out;
    logic       out_valid;

`ifdef MIXCOL_INVERSE_EN
    modport master (output in_valid, data_in, bypass, inv, input data_out, out_valid);
    modport slave  (input in_valid, data_in, bypass, inv, output data_out, out_valid);
`else
    modport master (output in_valid, data_in, bypass, input data_out, out_valid);
    modport slave  (input in_valid, data_in, bypass, output data_out, out_valid);
`endif
endinterface

// File: rtl/mix_column_serial.sv
// Byte-serial AES MixColumns: collects a column, emits its transform 1 byte/cycle.
// MIXCOL_INVERSE_EN adds an inv select for InvMixColumns.
module mix_column_serial #(
    parameter int PIPE_OUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mix_column_serial_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [1:0]      in_cnt;
    logic [3:0][7:0] col;
    logic [3:0][7:0] res;
    logic [3:0][7:0] res_n;
    logic [3:0][7:0] a;
    logic [0:0]      state;
    logic [1:0]      out_cnt;
    logic            load;
    logic            emit_vld;
    logic [7:0]      emit_dat;
    logic            inv_sel;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add over the 4 low coefficient bits; constant c folds to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] v, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

`ifdef MIXCOL_INVERSE_EN
    assign inv_sel = bus.inv;
`else
    assign inv_sel = 1'b0;
`endif

    assign load = bus.in_valid && (in_cnt == 2'd3);
    // Row 3 comes straight from the live input so the result is ready at the 4th-byte edge.
    assign a    = {bus.data_in, col[2], col[1], col[0]};

    always_comb begin
        res_n = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.bypass) begin
                res_n[k] = a[k];
            end else begin
                for (int j = 0; j < 4; j++) begin
                    case ((j - k) & 3)
                        0:       res_n[k] = res_n[k] ^ (inv_sel ? gmul(a[j], 4'hE) : xtime(a[j]));
                        1:       res_n[k] = res_n[k] ^ (inv_sel ? gmul(a[j], 4'hB) : (xtime(a[j]) ^ a[j]));
                        2:       res_n[k] = res_n[k] ^ (inv_sel ? gmul(a[j], 4'hD) : a[j]);
                        default: res_n[k] = res_n[k] ^ (inv_sel ? gmul(a[j], 4'h9) : a[j]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt <= 2'd0;
            col    <= '0;
        end else if (bus.in_valid) begin
            col[in_cnt] <= bus.data_in;
            in_cnt      <= in_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res     <= '0;
            state   <= IDLE;
            out_cnt <= 2'd0;
        end else begin
            if (load) res <= res_n;
            case (state)
                IDLE: begin
                    out_cnt <= 2'd0;
                    if (load) state <= EMIT;
                end
                default: begin
                    out_cnt <= load ? 2'd0 : out_cnt + 2'd1;
                    if (out_cnt == 2'd3 && !load) state <= IDLE;
                end
            endcase
        end
    end

    assign emit_vld = (state == EMIT);
    assign emit_dat = emit_vld ? res[out_cnt] : 8'h00;

    generate
        if (PIPE_OUT != 0) begin : g_pipe
            logic       vld_q;
            logic [7:0] dat_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    dat_q <= 8'h00;
                end else begin
                    vld_q <= emit_vld;
                    dat_q <= emit_dat;
                end
            end
            assign bus.out_valid = vld_q;
            assign bus.data_out  = dat_q;
        end else begin : g_direct
            assign bus.out_valid = emit_vld;
            assign bus.data_out  = emit_dat;
        end
    endgenerate
endmodule

// File: tb/tb_mix_column_serial.sv
// Scoreboard bench for mix_column_serial: driver pushes expected bytes with their due cycle, monitor pops on out_valid.
module tb_mix_column_serial;
    parameter int PIPE_OUT = 0;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    mix_column_serial_if bus();

    mix_column_serial #(.PIPE_OUT(PIPE_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out cyc=%0d got data_out=%h, required out_valid=0", cyc, bus.data_out);
            end else begin
                e = q.pop_front();
                if (bus.data_out !== e.dat || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_byte got %h @cyc %0d, required %h @cyc %0d", bus.data_out, cyc, e.dat, e.cyc);
                end
            end
        end else begin
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_out cyc=%0d got valid=%b data=%h, required 0/00", cyc, bus.out_valid, bus.data_out);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic byp, input logic iv);
        @(posedge clk); #1;
        bus.in_valid = v;
        bus.data_in  = d;
        bus.bypass   = byp;
`ifdef MIXCOL_INVERSE_EN
        bus.inv      = iv;
`else
        if (iv) $display("note: inv ignored in this build");
`endif
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Call right after the 4th byte is driven; result k is due 1+k(+pipe) cycles after it.
    task automatic expect_col(input logic [31:0] r);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.dat = r[31-8*k -: 8];
            e.cyc = cyc + 1 + k + PIPE_OUT;
            q.push_back(e);
        end
    endtask

    task automatic send_col(input logic [31:0] c, input logic byp, input logic iv, input logic [31:0] r);
        for (int k = 0; k < 4; k++)
            drive(1'b1, c[31-8*k -: 8], (k == 3) ? byp : 1'b0, (k == 3) ? iv : 1'b0);
        expect_col(r);
    endtask

    task automatic pulse_rst();
        int c0;
        exp_t keep[$];
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        c0 = cyc;
        foreach (q[i]) if (q[i].cyc <= c0) keep.push_back(q[i]);
        q = keep;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.data_in  = 8'h00;
        bus.bypass   = 1'b0;
`ifdef MIXCOL_INVERSE_EN
        bus.inv      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(); idle();

        // T1 FIPS-197 column
        send_col(32'hdb135345, 1'b0, 1'b0, 32'h8e4da1bc);
        repeat (6) idle();

        // T2 16 continuous bytes
        send_col(32'hf20a225c, 1'b0, 1'b0, 32'h9fdc589d);
        send_col(32'h01010101, 1'b0, 1'b0, 32'h01010101);
        send_col(32'hc6c6c6c6, 1'b0, 1'b0, 32'hc6c6c6c6);
        send_col(32'hd4d4d4d5, 1'b0, 1'b0, 32'hd5d5d7d6);
        repeat (6) idle();

        // T3 bypass on byte 3 passes through; bypass on byte 0 only is ignored
        send_col(32'hdb135345, 1'b1, 1'b0, 32'hdb135345);
        repeat (2) idle();
        drive(1'b1, 8'hdb, 1'b1, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        drive(1'b1, 8'h53, 1'b0, 1'b0);
        drive(1'b1, 8'h45, 1'b0, 1'b0);
        expect_col(32'h8e4da1bc);
        repeat (6) idle();

        // T4 gaps mid-column
        drive(1'b1, 8'hdb, 1'b0, 1'b0); idle();
        drive(1'b1, 8'h13, 1'b0, 1'b0); idle(); idle();
        drive(1'b1, 8'h53, 1'b0, 1'b0);
        drive(1'b1, 8'h45, 1'b0, 1'b0);
        expect_col(32'h8e4da1bc);
        repeat (6) idle();

        // T5 reset after a partial column, then reset during emission
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        pulse_rst();
        send_col(32'hdb135345, 1'b0, 1'b0, 32'h8e4da1bc);
        repeat (6) idle();
        send_col(32'hf20a225c, 1'b0, 1'b0, 32'h9fdc589d);
        idle(); idle();
        pulse_rst();
        repeat (6) idle();
        send_col(32'h01010101, 1'b0, 1'b0, 32'h01010101);
        repeat (6) idle();

`ifdef MIXCOL_INVERSE_EN
        // T6 inverse and bypass-over-inverse
        send_col(32'h8e4da1bc, 1'b0, 1'b1, 32'hdb135345);
        send_col(32'h9fdc589d, 1'b0, 1'b1, 32'hf20a225c);
        send_col(32'h8e4da1bc, 1'b1, 1'b1, 32'h8e4da1bc);
        repeat (6) idle();
`endif

        for (int i = 0; i < 40 && q.size() != 0; i++) idle();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending bytes, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
